// File: rtl/j1_instr_encoder_pkg.sv
// j1_instr_encoder_pkg: J1 instruction types, the INV constant and the request-to-word encoder
package j1_instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_LIT     = 3'd0,
        KIND_UBRANCH = 3'd1,
        KIND_ZBRANCH = 3'd2,
        KIND_CALL    = 3'd3,
        KIND_ALU     = 3'd4
    } req_kind_t;

    typedef enum logic [2:0] {
        TAG_UBRANCH = 3'd0,
        TAG_ZBRANCH = 3'd1,
        TAG_CALL    = 3'd2,
        TAG_ALU     = 3'd3
    } tag_t;

    typedef enum logic [3:0] {
        OP_T         = 4'd0,
        OP_N         = 4'd1,
        OP_T_PLUS_N  = 4'd2,
        OP_T_AND_N   = 4'd3,
        OP_T_OR_N    = 4'd4,
        OP_T_XOR_N   = 4'd5,
        OP_INV_T     = 4'd6,
        OP_N_EQ_T    = 4'd7,
        OP_N_LT_T    = 4'd8,
        OP_N_RSH_T   = 4'd9,
        OP_T_MINUS_1 = 4'd10,
        OP_R         = 4'd11,
        OP_MEM_T     = 4'd12,
        OP_N_LSH_T   = 4'd13,
        OP_DEPTH     = 4'd14,
        OP_N_ULT_T   = 4'd15
    } op_t;

    typedef logic [15:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WORD = 2'd1,
        ST_INV  = 2'd2
    } state_t;

    // ALU word that inverts T with every other field cleared
    localparam instr_t INSTR_INV_T = {TAG_ALU, 1'b0, OP_INV_T, 8'h00};

    // Literals carry 15 bits; a set bit 15 is stored inverted and fixed up by a following INV word
    function automatic instr_t encode_word(input req_kind_t kind, input logic [15:0] value);
        tag_t tag;
        tag = kind == KIND_UBRANCH ? TAG_UBRANCH :
              kind == KIND_ZBRANCH ? TAG_ZBRANCH :
              kind == KIND_CALL    ? TAG_CALL    : TAG_ALU;
        return kind == KIND_LIT ? {1'b1, value[15] ? ~value[14:0] : value[14:0]}
                                : {tag, value[12:0]};
    endfunction

endpackage

// File: rtl/j1_instr_encoder.sv
// j1_instr_encoder: encodes symbolic requests into J1 words with sequential addresses (option: J1_ENC_RANGE_CHECK_EN)
module j1_instr_encoder
    import j1_instr_encoder_pkg::*;
#(
    parameter logic [12:0] START_ADDR = 13'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [15:0] req_value,
    input  logic        org_valid,
    input  logic [12:0] org_addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_data,
    output logic [12:0] ins_addr,
    output logic        err
);

    state_t state;
    logic   inv_pending;
    logic   accept;
    logic   legal;

    assign req_ready = reset_n && !org_valid &&
                       (state == ST_IDLE || (state == ST_WORD && ins_ready && !inv_pending));
    assign accept    = req_valid && req_ready;
    assign ins_valid = state != ST_IDLE;

`ifdef J1_ENC_RANGE_CHECK_EN
    assign legal = req_kind <= 3'd4 &&
                   (req_kind == KIND_LIT ||
                    (req_value[15:13] == 3'b000 && !(req_kind == KIND_ALU && req_value[4])));
`else
    assign legal = req_kind <= 3'd4;
`endif

    // Output FSM, address counter and reject pulse; a rejected request leaves word, state and address alone
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            inv_pending <= 1'b0;
            ins_data    <= '0;
            ins_addr    <= START_ADDR;
            err         <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (ins_valid && ins_ready)
                ins_addr <= ins_addr + 13'd1;
            else if (state == ST_IDLE && org_valid)
                ins_addr <= org_addr;
            if (accept && legal) begin
                ins_data    <= encode_word(req_kind_t'(req_kind), req_value);
                inv_pending <= req_kind == KIND_LIT && req_value[15];
                state       <= ST_WORD;
            end else if (state == ST_WORD && ins_ready && inv_pending) begin
                ins_data    <= INSTR_INV_T;
                inv_pending <= 1'b0;
                state       <= ST_INV;
            end else if (state != ST_IDLE && ins_ready) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_j1_instr_encoder.sv
// tb_j1_instr_encoder: directed checks of encoding, handshakes, addressing and rejects
module tb_j1_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'd0;
    logic [15:0] req_value = 16'h0000;
    logic        org_valid = 1'b0;
    logic [12:0] org_addr = 13'h0000;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [15:0] ins_data;
    logic [12:0] ins_addr;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    j1_instr_encoder #(.START_ADDR(13'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_value(req_value), .org_valid(org_valid), .org_addr(org_addr),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_addr(ins_addr),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
        n_cmp++; if (ins_addr !== 13'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", ins_addr); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (ins_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", ins_data); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_literals();
        @(negedge clk);
        req_valid = 1'b1; req_kind = 3'd0; req_value = 16'h1234;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'h9234 || ins_addr !== 13'd0) begin n_fail++; $display("FAIL lit_pos: got v=%b %h@%0d want 1 9234@0", ins_valid, ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
        req_valid = 1'b1; req_kind = 3'd0; req_value = 16'h8000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'hFFFF || ins_addr !== 13'd1) begin n_fail++; $display("FAIL lit_neg_w1: got v=%b %h@%0d want 1 ffff@1", ins_valid, ins_data, ins_addr); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL lit_neg_ready: got %b want 0", req_ready); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'h6600 || ins_addr !== 13'd2) begin n_fail++; $display("FAIL lit_neg_inv: got v=%b %h@%0d want 1 6600@2", ins_valid, ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0 || ins_addr !== 13'd3) begin n_fail++; $display("FAIL lit_idle: got v=%b addr %0d want 0 3", ins_valid, ins_addr); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  kinds [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [15:0] vals  [4] = '{16'h0100, 16'h0010, 16'h1FFF, 16'h1C03};
        logic [15:0] exps  [4] = '{16'h0100, 16'h2010, 16'h5FFF, 16'h7C03};
        @(negedge clk);
        req_valid = 1'b1; req_kind = kinds[0]; req_value = vals[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++; if (ins_valid !== 1'b1 || ins_data !== exps[i] || ins_addr !== 13'(3 + i)) begin n_fail++; $display("FAIL b2b_%0d: got v=%b %h@%0d want 1 %h@%0d", i, ins_valid, ins_data, ins_addr, exps[i], 3 + i); end
            if (i < 3) begin req_kind = kinds[i + 1]; req_value = vals[i + 1]; end
            else req_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0 || ins_addr !== 13'd7) begin n_fail++; $display("FAIL b2b_end: got v=%b addr %0d want 0 7", ins_valid, ins_addr); end
    endtask

    task automatic test_stall();
        ins_ready = 1'b0;
        req_valid = 1'b1; req_kind = 3'd0; req_value = 16'hBFFF;
        @(posedge clk); @(negedge clk);
        req_kind = 3'd1; req_value = 16'h0005;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'hC000 || ins_addr !== 13'd7 || req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: got v=%b %h@%0d rdy=%b want 1 c000@7 rdy 0", i, ins_valid, ins_data, ins_addr, req_ready); end
            @(posedge clk); @(negedge clk);
        end
        req_valid = 1'b0;
        ins_ready = 1'b1;
        n_cmp++; if (ins_data !== 16'hC000 || ins_addr !== 13'd7) begin n_fail++; $display("FAIL stall_release: got %h@%0d want c000@7", ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'h6600 || ins_addr !== 13'd8) begin n_fail++; $display("FAIL stall_inv: got v=%b %h@%0d want 1 6600@8", ins_valid, ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0 || ins_addr !== 13'd9) begin n_fail++; $display("FAIL stall_end: got v=%b addr %0d want 0 9", ins_valid, ins_addr); end
    endtask

    task automatic test_org_wrap();
        org_valid = 1'b1; org_addr = 13'h1FFF;
        req_valid = 1'b1; req_kind = 3'd0; req_value = 16'h0001;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL org_blocks: got %b want 0", req_ready); end
        @(posedge clk); @(negedge clk);
        org_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b0 || ins_addr !== 13'h1FFF) begin n_fail++; $display("FAIL org_load: got v=%b addr %0d want 0 8191", ins_valid, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_data !== 16'h8001 || ins_addr !== 13'h1FFF) begin n_fail++; $display("FAIL wrap_a: got %h@%0d want 8001@8191", ins_data, ins_addr); end
        req_value = 16'h0002;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b1 || ins_data !== 16'h8002 || ins_addr !== 13'd0) begin n_fail++; $display("FAIL wrap_b: got v=%b %h@%0d want 1 8002@0", ins_valid, ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_illegal();
        req_valid = 1'b1; req_kind = 3'd6; req_value = 16'h0042;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (err !== 1'b1 || ins_valid !== 1'b0 || ins_addr !== 13'd1) begin n_fail++; $display("FAIL illegal: got err=%b v=%b addr %0d want 1 0 1", err, ins_valid, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", err); end
    endtask

    task automatic test_range();
        req_valid = 1'b1; req_kind = 3'd3; req_value = 16'h2000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
`ifdef J1_ENC_RANGE_CHECK_EN
        n_cmp++; if (err !== 1'b1 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL range_reject: got err=%b v=%b want 1 0", err, ins_valid); end
`else
        n_cmp++; if (err !== 1'b0 || ins_valid !== 1'b1 || ins_data !== 16'h4000 || ins_addr !== 13'd1) begin n_fail++; $display("FAIL range_trunc: got err=%b v=%b %h@%0d want 0 1 4000@1", err, ins_valid, ins_data, ins_addr); end
`endif
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ins_ready = 1'b0;
        req_valid = 1'b1; req_kind = 3'd0; req_value = 16'h8000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        ins_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_data !== 16'h6600) begin n_fail++; $display("FAIL mid_inv: got %h want 6600", ins_data); end
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        n_cmp++; if (ins_valid !== 1'b0 || ins_addr !== 13'd0 || ins_data !== 16'h0000) begin n_fail++; $display("FAIL mid_reset: got v=%b %h@%0d want 0 0000@0", ins_valid, ins_data, ins_addr); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got v=%b want 0", ins_valid); end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_back_to_back();
        test_stall();
        test_org_wrap();
        test_illegal();
        test_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
